// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: per-channel arm, BCD snooze with a per-trigger limit,
// ring timeout, lowest-index arbitration and sticky missed flags. Drives beep_en for alarm_music.
module multi_alarm_ctrl #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           time_num,
  input  logic                  sec_tick,
  input  logic                  key_stop,
  input  logic                  key_snooze,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [15:0]           wr_hhmm,
  input  logic                  wr_arm,
  output logic [NUM_ALARMS-1:0] alarm_armed,
  output logic [NUM_ALARMS-1:0] snooze_pend,
  output logic [NUM_ALARMS-1:0] missed,
  output logic                  ringing,
  output logic [IDX_W-1:0]      ring_idx,
  output logic                  beep_en
);

  localparam int unsigned CNT_W = $clog2(MAX_SNOOZE + 2);

  typedef enum logic [0:0] {StIdle, StRing} state_e;

  state_e r_state, w_state_nxt;

  logic [15:0]           r_alm_time [NUM_ALARMS];
  logic [15:0]           w_alm_time_nxt [NUM_ALARMS];
  logic [15:0]           r_snz_tgt [NUM_ALARMS];
  logic [15:0]           w_snz_tgt_nxt [NUM_ALARMS];
  logic [CNT_W-1:0]      r_snz_cnt [NUM_ALARMS];
  logic [CNT_W-1:0]      w_snz_cnt_nxt [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_armed, w_armed_nxt;
  logic [NUM_ALARMS-1:0] r_pend, w_pend_nxt;
  logic [NUM_ALARMS-1:0] r_missed, w_missed_nxt;
  logic [7:0]            r_ring_cnt, w_ring_cnt_nxt;
  logic [IDX_W-1:0]      r_ring_idx, w_ring_idx_nxt;

  logic                  w_match_en;
  logic                  w_wr_valid;
  logic [NUM_ALARMS-1:0] w_match;
  logic [NUM_ALARMS-1:0] w_wr_hit;
  logic [NUM_ALARMS-1:0] w_ring_oh;
  logic [NUM_ALARMS-1:0] w_win_oh;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_snz_exhausted;
  logic [15:0]           w_snz_time;
  logic [7:0]            w_ring_cnt_inc;
  logic                  w_timeout;

  // HH:MM + SNOOZE_MIN in BCD; minutes carry into hours, hours wrap 23 -> 00.
  function automatic logic [15:0] snooze_time(input logic [15:0] hhmm);
    logic [7:0] min_bin;
    logic [7:0] hr_bin;
    min_bin = 8'(hhmm[7:4]) * 8'd10 + 8'(hhmm[3:0]) + 8'(SNOOZE_MIN);
    hr_bin  = 8'(hhmm[15:12]) * 8'd10 + 8'(hhmm[11:8]);
    if (min_bin >= 8'd60) begin
      min_bin = min_bin - 8'd60;
      hr_bin  = hr_bin + 8'd1;
    end
    if (hr_bin >= 8'd24) begin
      hr_bin = 8'd0;
    end
    return {4'(hr_bin / 8'd10), 4'(hr_bin % 8'd10), 4'(min_bin / 8'd10), 4'(min_bin % 8'd10)};
  endfunction

  assign w_match_en     = sec_tick && (time_num[7:0] == 8'h00);
  assign w_wr_valid     = wr_en && (32'(wr_idx) < NUM_ALARMS);
  assign w_snz_time     = snooze_time(time_num[23:8]);
  assign w_ring_cnt_inc = r_ring_cnt + 8'd1;
  assign w_timeout      = sec_tick && (w_ring_cnt_inc == 8'(RING_SEC));

  always_comb begin : decode
    w_match         = '0;
    w_wr_hit        = '0;
    w_ring_oh       = '0;
    w_snz_exhausted = 1'b0;
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      w_match[i]   = w_match_en &&
                     ((r_armed[i] && (time_num[23:8] == r_alm_time[i])) ||
                      (r_pend[i]  && (time_num[23:8] == r_snz_tgt[i])));
      w_wr_hit[i]  = w_wr_valid && (wr_idx == IDX_W'(i));
      w_ring_oh[i] = (r_ring_idx == IDX_W'(i));
      if (w_ring_oh[i] && (r_snz_cnt[i] >= CNT_W'(MAX_SNOOZE))) begin
        w_snz_exhausted = 1'b1;
      end
    end
  end

  // Lowest matching index wins: scan downwards so the last hit is the smallest.
  always_comb begin : arbiter
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_win_idx   = IDX_W'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    w_state_nxt    = r_state;
    w_alm_time_nxt = r_alm_time;
    w_snz_tgt_nxt  = r_snz_tgt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_armed_nxt    = r_armed;
    w_pend_nxt     = r_pend;
    w_missed_nxt   = r_missed;
    w_ring_cnt_nxt = r_ring_cnt;
    w_ring_idx_nxt = r_ring_idx;

    case (r_state)
      StIdle: begin
        if (|w_match) begin
          w_state_nxt    = StRing;
          w_ring_idx_nxt = w_win_idx;
          w_ring_cnt_nxt = 8'd0;
          w_pend_nxt     = r_pend & ~w_match;
          w_missed_nxt   = r_missed | (w_match & ~w_win_oh);
        end
      end
      StRing: begin
        w_missed_nxt = r_missed | (w_match & ~w_ring_oh);
        w_pend_nxt   = r_pend & ~(w_match & ~w_ring_oh);
        if (sec_tick) begin
          w_ring_cnt_nxt = w_ring_cnt_inc;
        end
        if (key_stop || key_snooze || w_timeout) begin
          w_state_nxt    = StIdle;
          w_ring_cnt_nxt = 8'd0;
          w_ring_idx_nxt = '0;
          for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (w_ring_oh[i]) begin
              if (key_snooze && !key_stop && !w_snz_exhausted) begin
                w_snz_tgt_nxt[i] = w_snz_time;
                w_pend_nxt[i]    = 1'b1;
                w_snz_cnt_nxt[i] = r_snz_cnt[i] + CNT_W'(1);
              end else begin
                w_snz_cnt_nxt[i] = '0;
                // Only an unanswered ring counts as missed.
                if (!key_stop && !key_snooze) begin
                  w_missed_nxt[i] = 1'b1;
                end
              end
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (w_wr_hit[i]) begin
        w_alm_time_nxt[i] = wr_hhmm;
        w_armed_nxt[i]    = wr_arm;
        w_pend_nxt[i]     = 1'b0;
        w_snz_cnt_nxt[i]  = '0;
        w_missed_nxt[i]   = 1'b0;
      end
    end
    if ((r_state == StRing) && |(w_wr_hit & w_ring_oh)) begin
      w_state_nxt    = StIdle;
      w_ring_cnt_nxt = 8'd0;
      w_ring_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_alm_time <= '{default: '0};
      r_snz_tgt  <= '{default: '0};
      r_snz_cnt  <= '{default: '0};
      r_armed    <= '0;
      r_pend     <= '0;
      r_missed   <= '0;
      r_ring_cnt <= 8'd0;
      r_ring_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_alm_time <= w_alm_time_nxt;
      r_snz_tgt  <= w_snz_tgt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_armed    <= w_armed_nxt;
      r_pend     <= w_pend_nxt;
      r_missed   <= w_missed_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_ring_idx <= w_ring_idx_nxt;
    end
  end

  assign alarm_armed = r_armed;
  assign snooze_pend = r_pend;
  assign missed      = r_missed;
  assign ringing     = (r_state == StRing);
  assign ring_idx    = r_ring_idx;
  assign beep_en     = ringing;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: a vector table for arming/arbitration, then
// hand-built sequences for snooze, snooze limit, timeout and reset.
module tb_multi_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] time_num;
  logic        sec_tick, key_stop, key_snooze, wr_en, wr_arm;
  logic [1:0]  wr_idx;
  logic [15:0] wr_hhmm;
  logic [3:0]  alarm_armed, snooze_pend, missed;
  logic        ringing, beep_en;
  logic [1:0]  ring_idx;

  always #5 clk = ~clk;

  multi_alarm_ctrl #(
    .NUM_ALARMS(4), .IDX_W(2), .RING_SEC(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)
  ) dut (
    .clk(clk), .rst(rst), .time_num(time_num), .sec_tick(sec_tick),
    .key_stop(key_stop), .key_snooze(key_snooze), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_hhmm(wr_hhmm), .wr_arm(wr_arm), .alarm_armed(alarm_armed),
    .snooze_pend(snooze_pend), .missed(missed), .ringing(ringing),
    .ring_idx(ring_idx), .beep_en(beep_en)
  );

  typedef struct packed {
    logic        rst;
    logic [23:0] t;
    logic        tick, ks, kz, we;
    logic [1:0]  wi;
    logic [15:0] wh;
    logic        wa;
    logic [3:0]  e_arm, e_pend, e_miss;
    logic        e_ring;
    logic [1:0]  e_idx;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "";
  vec_t  tbl [20];

  function automatic vec_t mk(input logic r, input logic [23:0] t, input logic tk,
                              input logic ks, input logic kz, input logic we,
                              input logic [1:0] wi, input logic [15:0] wh, input logic wa,
                              input logic [3:0] ea, input logic [3:0] ep,
                              input logic [3:0] em, input logic er, input logic [1:0] ei);
    vec_t v;
    v.rst = r; v.t = t; v.tick = tk; v.ks = ks; v.kz = kz; v.we = we;
    v.wi = wi; v.wh = wh; v.wa = wa;
    v.e_arm = ea; v.e_pend = ep; v.e_miss = em; v.e_ring = er; v.e_idx = ei;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [15:0] act, exp;
    rst = v.rst; time_num = v.t; sec_tick = v.tick; key_stop = v.ks; key_snooze = v.kz;
    wr_en = v.we; wr_idx = v.wi; wr_hhmm = v.wh; wr_arm = v.wa;
    @(posedge clk);
    #1;
    act = {alarm_armed, snooze_pend, missed, ringing, ring_idx, beep_en};
    exp = {v.e_arm, v.e_pend, v.e_miss, v.e_ring, v.e_idx, v.e_ring};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got arm=%b pend=%b miss=%b ring=%b idx=%0d beep=%b, want arm=%b pend=%b miss=%b ring=%b idx=%0d beep=%b",
               phase, n_vec, alarm_armed, snooze_pend, missed, ringing, ring_idx, beep_en,
               v.e_arm, v.e_pend, v.e_miss, v.e_ring, v.e_idx, v.e_ring);
    end
  endtask

  task automatic tick_at(input logic [23:0] t, input logic [3:0] ea, input logic [3:0] ep,
                         input logic [3:0] em, input logic er, input logic [1:0] ei);
    apply(mk(1'b0, t, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, ea, ep, em, er, ei));
  endtask

  task automatic key(input logic ks, input logic kz, input logic [23:0] t,
                     input logic [3:0] ea, input logic [3:0] ep, input logic [3:0] em,
                     input logic er, input logic [1:0] ei);
    apply(mk(1'b0, t, 1'b0, ks, kz, 1'b0, 2'd0, 16'h0, 1'b0, ea, ep, em, er, ei));
  endtask

  task automatic wr(input logic [1:0] wi, input logic [15:0] wh, input logic wa,
                    input logic [3:0] ea, input logic [3:0] ep, input logic [3:0] em,
                    input logic er, input logic [1:0] ei);
    apply(mk(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, wi, wh, wa, ea, ep, em, er, ei));
  endtask

  initial begin
    //           rst  time        tk  ks  kz  we  wi  hhmm     wa   arm     pend    miss    rg  idx
    tbl[0]  = mk(1, 24'h000000, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 24'h000000, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 24'h000000, 0, 0, 0, 1, 1, 16'h0730, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[3]  = mk(0, 24'h072959, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[4]  = mk(0, 24'h073000, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[5]  = mk(0, 24'h073030, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[6]  = mk(0, 24'h073000, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    tbl[7]  = mk(0, 24'h073000, 0, 0, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    tbl[8]  = mk(0, 24'h073005, 0, 1, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[9]  = mk(0, 24'h073006, 0, 1, 0, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[10] = mk(0, 24'h073007, 0, 0, 1, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    tbl[11] = mk(0, 24'h000000, 0, 0, 0, 1, 0, 16'h1200, 1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    tbl[12] = mk(0, 24'h000000, 0, 0, 0, 1, 2, 16'h1200, 1, 4'b0111, 4'b0000, 4'b0000, 0, 0);
    tbl[13] = mk(0, 24'h120000, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0111, 4'b0000, 4'b0100, 1, 0);
    tbl[14] = mk(0, 24'h120003, 0, 1, 0, 0, 0, 16'h0000, 0, 4'b0111, 4'b0000, 4'b0100, 0, 0);
    tbl[15] = mk(0, 24'h000000, 0, 0, 0, 1, 2, 16'h1200, 1, 4'b0111, 4'b0000, 4'b0000, 0, 0);
    tbl[16] = mk(0, 24'h000000, 0, 0, 0, 1, 0, 16'h1200, 0, 4'b0110, 4'b0000, 4'b0000, 0, 0);
    tbl[17] = mk(0, 24'h120000, 1, 0, 0, 0, 0, 16'h0000, 0, 4'b0110, 4'b0000, 4'b0000, 1, 2);
    tbl[18] = mk(0, 24'h000000, 0, 0, 0, 1, 1, 16'h0730, 1, 4'b0110, 4'b0000, 4'b0000, 1, 2);
    tbl[19] = mk(0, 24'h000000, 0, 0, 0, 1, 2, 16'h1200, 1, 4'b0110, 4'b0000, 4'b0000, 0, 0);

    phase = "table";
    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Snooze across midnight, then the normal daily trigger.
    phase = "snooze_wrap";
    wr(2'd3, 16'h2358, 1'b1,            4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h235800,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b0, 1'b1, 24'h235810,         4'b1110, 4'b1000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h000300,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b1, 1'b0, 24'h000305,         4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h235800,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b1, 1'b0, 24'h235801,         4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Three snoozes allowed; the fourth acts as stop.
    phase = "snooze_limit";
    tick_at(24'h235800,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b0, 1'b1, 24'h235800,         4'b1110, 4'b1000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h000300,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b0, 1'b1, 24'h000300,         4'b1110, 4'b1000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h000700,                 4'b1110, 4'b1000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h000800,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b0, 1'b1, 24'h000800,         4'b1110, 4'b1000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h001300,                 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd3);
    key(1'b0, 1'b1, 24'h001300,         4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h001800,                 4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Minute carry into a BCD hour tens digit: 09:57 + 5 -> 10:02.
    phase = "snooze_carry";
    wr(2'd0, 16'h0957, 1'b1,            4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h095700,                 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0);
    key(1'b0, 1'b1, 24'h095720,         4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h100200,                 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0);
    key(1'b1, 1'b0, 24'h100201,         4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Ring timeout on the 60th tick; ch2 matches mid-ring and is marked missed.
    phase = "timeout";
    tick_at(24'h073000,                 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1);
    for (int k = 1; k <= 60; k++) begin
      logic [3:0] m_pre, m_post;
      m_pre  = (k > 30)  ? 4'b0100 : 4'b0000;
      m_post = (k >= 30) ? 4'b0100 : 4'b0000;
      if (k == 60) m_post = m_post | 4'b0010;
      apply(mk(1'b0, 24'h073115, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0,
               4'b1111, 4'b0000, m_pre, 1'b1, 2'd1));
      tick_at((k == 30) ? 24'h120000 : 24'h073115,
              4'b1111, 4'b0000, m_post, (k < 60), (k < 60) ? 2'd1 : 2'd0);
    end
    wr(2'd1, 16'h0730, 1'b1,            4'b1111, 4'b0000, 4'b0100, 1'b0, 2'd0);
    wr(2'd2, 16'h1200, 1'b1,            4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Stop beats snooze in the same cycle; reset mid-ring clears everything.
    phase = "stop_rst";
    tick_at(24'h073000,                 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1);
    key(1'b1, 1'b1, 24'h073010,         4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick_at(24'h073000,                 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1);
    apply(mk(1'b1, 24'h120000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 1'b0,
             4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
    tick_at(24'h073000,                 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_alarm_ctrl.md
Name: multi_alarm_ctrl

Overview:
- Parametrised successor to the single-alarm compare path: N independently programmable alarm channels checked against the running clock.
- Adds per-channel arm/disarm, snooze with BCD time arithmetic and snooze limit, ring timeout, lowest-index arbitration, and sticky missed flags.
- Sits between time_counter, which supplies time_num and the seconds tick, and alarm_music, which is driven by beep_en. Keys and the adjust logic drive the stop, snooze and write strobes.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16).
- IDX_W, 2, channel index width; must be at least clog2(NUM_ALARMS), minimum 1.
- RING_SEC, 60, seconds a ring lasts before auto-stop (1..255).
- SNOOZE_MIN, 5, minutes added per snooze (1..59).
- MAX_SNOOZE, 3, snoozes allowed per trigger; the next snooze acts as stop.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- time_num  in  24  current time in BCD as HH,MM,SS: [23:16] hours, [15:8] minutes, [7:0] seconds.
- sec_tick  in  1  one-cycle pulse; time_num already holds the new second in this cycle.
- key_stop  in  1  one-cycle stop pulse.
- key_snooze  in  1  one-cycle snooze pulse.
- wr_en  in  1  channel write strobe.
- wr_idx  in  IDX_W  channel being written.
- wr_hhmm  in  16  BCD alarm time as HH,MM.
- wr_arm  in  1  arm bit written with the time.
- alarm_armed  out  NUM_ALARMS  per-channel armed flags.
- snooze_pend  out  NUM_ALARMS  per-channel snooze-pending flags.
- missed  out  NUM_ALARMS  sticky missed flags.
- ringing  out  1  ring in progress.
- ring_idx  out  IDX_W  channel currently ringing (0 when idle).
- beep_en  out  1  equals ringing; gates alarm_music.

Behaviour:
- Reset: all outputs 0. Internal alarm times, snooze targets, snooze counts and ring counter cleared. FSM in IDLE.
- Per-channel state: alarm time, armed flag, snooze target, snooze_pend, snooze count.
- Write (wr_en, with wr_idx < NUM_ALARMS):
  - Loads the alarm time, sets armed = wr_arm.
  - Clears snooze_pend, snooze count and missed for that channel.
  - If that channel is ringing, the ring stops in the same edge and the FSM goes to IDLE.
  - Writes with wr_idx >= NUM_ALARMS are ignored.
  - Inputs are not BCD-validated.
- Match, evaluated only in cycles with sec_tick=1 and time_num[7:0]==8'h00. Channel i matches if:
  - it is armed and time_num[23:8] equals its alarm time, or
  - snooze_pend is set and time_num[23:8] equals its snooze target.
- FSM IDLE:
  - On any match, the lowest matching index wins.
  - Next edge: ringing=1, ring_idx=winner, ring counter=0, and the winner's snooze_pend clears.
  - Other matching channels set missed. Their snooze_pend also clears.
- FSM RINGING:
  - Ring counter increments on each sec_tick.
  - key_stop returns to IDLE on the next edge and clears the snooze count.
  - key_snooze, when snooze count < MAX_SNOOZE:
    - snooze target = time_num[23:8] at the moment of the press, plus SNOOZE_MIN minutes, in BCD.
    - Minutes wrap at 59 with carry into hours; hours wrap 23 to 00.
    - Sets snooze_pend, increments the snooze count, returns to IDLE.
  - key_snooze when snooze count == MAX_SNOOZE behaves exactly as key_stop.
  - key_stop and key_snooze in the same cycle: stop wins.
  - When the ring counter reaches RING_SEC on a sec_tick, auto-stop: return to IDLE, set missed for the ringing channel, clear its snooze count.
  - A match for any other channel while RINGING sets that channel's missed bit; the current ring continues.
  - A write to another channel does not affect the ring.
- Key pulses in IDLE are ignored.
- The alarm stays armed after ringing; it retriggers daily.
- Latency: ringing rises exactly 1 clk after the qualifying sec_tick cycle and falls 1 clk after a key or timeout.
- A rst during RINGING takes effect at the next edge regardless of other inputs.

Test Plan:
- Arm ch1 at 07:30. Drive time_num 07:29:59 then 07:30:00 with sec_tick. Required: ringing=1 and ring_idx=1 one clk later, beep_en=1. Then key_stop gives ringing=0 and missed[1]=0.
- Arm ch0 and ch2 at 12:00. Tick into 12:00:00. Required: ring_idx=0, missed[2]=1. Then a write to ch2 clears missed[2].
- Ch3 at 23:58, SNOOZE_MIN=5. Ring, then key_snooze. Required: snooze_pend[3]=1, ringing=0. Tick into 00:03:00: ringing=1 and ring_idx=3 (hour wrap). Tick into 23:58:00 the next day: the normal trigger still fires.
- MAX_SNOOZE=3: snooze three times, with each re-ring at +5 minutes. The fourth key_snooze acts as stop: snooze_pend=0, no re-ring at +5 minutes.
- RING_SEC=60, no keys. Required: ringing drops on the 60th sec_tick after start, and missed=1 for that channel.
- Apply key_stop and key_snooze in the same cycle: stop wins, snooze_pend=0. Then assert rst mid-ring: all outputs 0 at the next edge.
